// File: rtl/inst_fetch_pkg.sv
// Shared constants for the MIPS fetch stage: reset PC, FSM encodings, PC-select codes.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_VALID = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    localparam int unsigned WORD_INC = 4;

    typedef enum logic [1:0] {
        PC_SEL_HOLD  = 2'b00,
        PC_SEL_INC   = 2'b01,
        PC_SEL_REDIR = 2'b10,
        PC_SEL_PEND  = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC selector for the fetch stage: hold, PC+4, redirect target or pending target.
module inst_fetch_pc_next
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_redirect_target,
    input  logic [ADDR_W-1:0] i_pend_target,
    input  pc_sel_e           i_sel,
    output logic [ADDR_W-1:0] o_pc_next
);

    // Increment wraps naturally modulo 2^ADDR_W.
    always_comb begin
        o_pc_next = i_pc;
        case (i_sel)
            PC_SEL_INC:   o_pc_next = i_pc + ADDR_W'(WORD_INC);
            PC_SEL_REDIR: o_pc_next = i_redirect_target;
            PC_SEL_PEND:  o_pc_next = i_pend_target;
            default:      o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// MIPS fetch stage: owns the PC, reads imem over req/ack, hands words to decode over valid/ready.
// Optional FETCH_DELAY_SLOT_EN defers redirects until the branch delay slot has been consumed.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_pc_out;

    logic [1:0]        w_next_state;
    pc_sel_e           w_pc_sel;
    logic              w_capture;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_target_aligned;
    logic [ADDR_W-1:0] w_pend_target_in;

    assign w_target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};

`ifdef FETCH_DELAY_SLOT_EN
    logic              r_pend_valid;
    logic              r_pend_armed;
    logic [ADDR_W-1:0] r_pend_target;

    // A redirect seen on the delay-slot consume cycle replaces the older target.
    assign w_pend_target_in = redirect ? w_target_aligned : r_pend_target;
`else
    assign w_pend_target_in = '0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_pc_sel     = PC_SEL_HOLD;
        w_capture    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (halt) begin
                    w_next_state = ST_HALT;
`ifndef FETCH_DELAY_SLOT_EN
                end else if (redirect) begin
                    w_pc_sel = PC_SEL_REDIR;
`endif
                end else if (imem_ack) begin
                    w_next_state = ST_VALID;
                    w_capture    = 1'b1;
                end
            end
            ST_VALID: begin
                if (halt) begin
                    w_next_state = ST_HALT;
`ifndef FETCH_DELAY_SLOT_EN
                end else if (redirect) begin
                    w_pc_sel     = PC_SEL_REDIR;
                    w_next_state = ST_FETCH;
`endif
                end else if (inst_ready) begin
                    w_next_state = ST_FETCH;
`ifdef FETCH_DELAY_SLOT_EN
                    w_pc_sel = (r_pend_valid && r_pend_armed) ? PC_SEL_PEND : PC_SEL_INC;
`else
                    w_pc_sel = PC_SEL_INC;
`endif
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    inst_fetch_pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .i_pc              (r_pc),
        .i_redirect_target (w_target_aligned),
        .i_pend_target     (w_pend_target_in),
        .i_sel             (w_pc_sel),
        .o_pc_next         (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_inst   <= 32'h0;
            r_pc_out <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_capture) begin
                r_inst   <= imem_rdata;
                r_pc_out <= r_pc;
            end
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    // Armed means the word now in flight or held is the delay slot, so its
    // consumption triggers the jump; otherwise the branch itself is still held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_armed  <= 1'b0;
            r_pend_target <= '0;
        end else if (halt || r_state == ST_HALT) begin
            r_pend_valid <= 1'b0;
            r_pend_armed <= 1'b0;
        end else if (w_pc_sel == PC_SEL_PEND) begin
            r_pend_valid <= 1'b0;
            r_pend_armed <= 1'b0;
        end else begin
            if (redirect) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_target_aligned;
            end
            if (redirect && !r_pend_valid) begin
                r_pend_armed <= (r_state == ST_FETCH) || (r_state == ST_VALID && inst_ready);
            end else if (r_pend_valid && r_state == ST_VALID && inst_ready) begin
                r_pend_armed <= 1'b1;
            end
        end
    end
`endif

    assign imem_req   = (r_state == ST_FETCH);
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = (r_state == ST_VALID);
    assign pc_out     = r_pc_out;
    assign pc_plus4   = r_pc_out + ADDR_W'(WORD_INC);
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a per-cycle vector table plus hand-written
// redirect, wrap-around and delay-slot sequences.
module tb_inst_fetch;

    localparam logic [31:0] R = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic        ackEn;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rstN;
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] tgt;
        logic        hlt;
        logic        chk;
        logic        chkInst;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPcOut;
        logic [31:0] expInst;
        logic        expHalted;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Instruction memory: answers in the request cycle with an address-derived word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_ack   = ackEn & imem_req;
    assign imem_rdata = memWord(imem_addr);

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic ack, input logic ready,
                                 input logic redir, input logic [31:0] tgt, input logic hlt);
        rst_n           = rstN;
        ackEn           = ack;
        inst_ready      = ready;
        redirect        = redir;
        redirect_target = tgt;
        halt            = hlt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkState(input string tag, input logic expReq, input logic [31:0] expAddr,
                              input logic expValid, input logic [31:0] expPcOut, input logic expHalted);
        checkOutput({tag, " imem_req"},   {31'b0, imem_req},   {31'b0, expReq});
        checkOutput({tag, " imem_addr"},  imem_addr,           expAddr);
        checkOutput({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, expValid});
        checkOutput({tag, " pc_out"},     pc_out,              expPcOut);
        checkOutput({tag, " pc_plus4"},   pc_plus4,            expPcOut + 32'd4);
        checkOutput({tag, " halted"},     {31'b0, halted},     {31'b0, expHalted});
    endtask

    task automatic addVec(input logic rstN, input logic ack, input logic ready, input logic redir,
                          input logic [31:0] tgt, input logic hlt, input logic chk, input logic chkInst,
                          input logic expReq, input logic [31:0] expAddr, input logic expValid,
                          input logic [31:0] expPcOut, input logic [31:0] expInst, input logic expHalted);
        vec_t v;
        v.rstN = rstN;   v.ack = ack;         v.ready = ready;       v.redir = redir;
        v.tgt = tgt;     v.hlt = hlt;         v.chk = chk;           v.chkInst = chkInst;
        v.expReq = expReq;     v.expAddr = expAddr;   v.expValid = expValid;
        v.expPcOut = expPcOut; v.expInst = expInst;   v.expHalted = expHalted;
        vecs.push_back(v);
    endtask

    initial begin
        string tag;

        // Each row: inputs driven this cycle, and the state visible before the next edge.
        addVec(0,0,0,0,0,0, 0,0, 0,0,      0,0,      0,            0);
        addVec(1,1,1,0,0,0, 1,1, 1,R,      0,R,      0,            0);
        addVec(1,1,1,0,0,0, 1,1, 0,R,      1,R,      memWord(R),   0);
        addVec(1,1,1,0,0,0, 1,0, 1,R+4,    0,R,      0,            0);
        addVec(1,1,1,0,0,0, 1,1, 0,R+4,    1,R+4,    memWord(R+4), 0);
        addVec(1,1,0,0,0,0, 1,0, 1,R+8,    0,R+4,    0,            0);
        for (int k = 0; k < 5; k++)
            addVec(1,1,0,0,0,0, 1,1, 0,R+8, 1,R+8,   memWord(R+8), 0);
        addVec(1,1,1,0,0,0, 1,1, 0,R+8,    1,R+8,    memWord(R+8), 0);
        addVec(1,0,1,0,0,0, 1,0, 1,R+12,   0,R+8,    0,            0);
        addVec(1,1,0,0,0,0, 1,0, 1,R+12,   0,R+8,    0,            0);
        addVec(1,0,0,0,0,1, 1,1, 0,R+12,   1,R+12,   memWord(R+12),0);
        addVec(1,1,1,1,32'h0040_0300,0, 1,0, 0,R+12, 0,R+12, 0,    1);
        addVec(0,1,0,0,0,0, 1,0, 0,R+12,   0,R+12,   0,            1);
        addVec(0,1,0,0,0,0, 1,1, 1,R,      0,R,      0,            0);
        addVec(1,0,0,0,0,0, 1,1, 1,R,      0,R,      0,            0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].tgt, vecs[i].hlt);
            if (vecs[i].chk) begin
                tag = $sformatf("row%0d", i);
                checkState(tag, vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid,
                           vecs[i].expPcOut, vecs[i].expHalted);
                if (vecs[i].chkInst)
                    checkOutput({tag, " inst"}, inst, vecs[i].expInst);
            end
            tick();
        end

        // Redirect with a misaligned target coinciding with an ack.
        applyStimulus(1,1,0,1,32'h0040_0103,0);
        tick();
`ifndef FETCH_DELAY_SLOT_EN
        checkState("redirAck drop", 1, 32'h0040_0100, 0, R, 0);
        applyStimulus(1,1,0,0,0,0);
        tick();
`else
        checkState("redirAck slot", 0, R, 1, R, 0);
        checkOutput("redirAck slot inst", inst, memWord(R));
        applyStimulus(1,0,1,0,0,0);
        tick();
        checkState("redirAck jump", 1, 32'h0040_0100, 0, R, 0);
        applyStimulus(1,1,0,0,0,0);
        tick();
`endif
        checkState("redirAck target", 0, 32'h0040_0100, 1, 32'h0040_0100, 0);
        checkOutput("redirAck target inst", inst, memWord(32'h0040_0100));
        applyStimulus(1,0,1,0,0,0);
        tick();
        checkState("redirAck next", 1, 32'h0040_0104, 0, 32'h0040_0100, 0);

        // PC wrap from the top word of the address space.
        applyStimulus(1,0,0,1,32'hFFFF_FFFC,0);
        tick();
`ifdef FETCH_DELAY_SLOT_EN
        checkState("wrap slot fetch", 1, 32'h0040_0104, 0, 32'h0040_0100, 0);
        applyStimulus(1,1,0,0,0,0);
        tick();
        checkState("wrap slot held", 0, 32'h0040_0104, 1, 32'h0040_0104, 0);
        applyStimulus(1,0,1,0,0,0);
        tick();
`endif
        checkOutput("wrap fetch addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1,1,0,0,0,0);
        tick();
        checkState("wrap held", 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
        checkOutput("wrap pc_plus4 zero", pc_plus4, 32'h0);
        applyStimulus(1,0,1,0,0,0);
        tick();
        checkState("wrap next", 1, 32'h0, 0, 32'hFFFF_FFFC, 0);

        // Branch at 0x00400010 redirects to 0x00400200 while its word is held.
        applyStimulus(0,0,0,0,0,0);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1,1,1,0,0,0);
            tick();
            tick();
        end
        checkState("slot walk", 1, R+16, 0, R+12, 0);
        applyStimulus(1,1,0,0,0,0);
        tick();
        checkState("slot branch held", 0, R+16, 1, R+16, 0);
        applyStimulus(1,0,0,1,32'h0040_0200,0);
        tick();
`ifndef FETCH_DELAY_SLOT_EN
        checkState("slot immediate", 1, 32'h0040_0200, 0, R+16, 0);
`else
        checkState("slot branch still held", 0, R+16, 1, R+16, 0);
        applyStimulus(1,0,1,0,0,0);
        tick();
        checkState("slot fetch", 1, R+20, 0, R+16, 0);
        applyStimulus(1,1,0,0,0,0);
        tick();
        checkState("slot delivered", 0, R+20, 1, R+20, 0);
        checkOutput("slot inst", inst, memWord(R+20));
        applyStimulus(1,0,1,0,0,0);
        tick();
        checkState("slot jump", 1, 32'h0040_0200, 0, R+20, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder/control unit in the single-issue MIPS core.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Holds each fetched word in an output register and hands it to decode over a valid/ready handshake.
- Accepts PC redirects (J/JAL/JR/taken branch) resolved downstream, and a halt request (SYSCALL exit).

Parameters:
- RESET_PC, 32'h0040_0000: PC loaded on reset (MIPS text base).
- ADDR_W, 32: PC / memory address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  ADDR_W  word address of the request; equals the current PC and is stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, sampled when imem_req & imem_ack.
- inst  out  32  registered instruction presented to decode.
- inst_valid  out  1  inst is valid.
- inst_ready  in  1  decode consumes inst this cycle when inst_valid=1.
- pc_out  out  ADDR_W  PC of the word held in inst.
- pc_plus4  out  ADDR_W  pc_out+4; the JAL link value.
- redirect  in  1  one-cycle pulse that loads redirect_target as the next fetch PC.
- redirect_target  in  ADDR_W  target address; bits [1:0] forced to 0 internally.
- halt  in  1  one-cycle pulse (SYSCALL exit) that stops fetching.
- halted  out  1  high while in the HALT state.

Behaviour:
Reset (rst_n=0 at an edge):
- PC=RESET_PC, state=FETCH.
- inst=0, inst_valid=0, pc_out=RESET_PC, halted=0.
- Reset overrides any in-flight request; an ack arriving in the reset cycle is dropped.

States:
- FETCH: imem_req=1, imem_addr=PC.
  - On imem_ack: inst<=imem_rdata, pc_out<=PC, inst_valid<=1, go to VALID.
- VALID: inst_valid=1, imem_req=0.
  - On inst_ready: PC<=PC+4 (modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0), inst_valid<=0, go to FETCH.
  - Latency: minimum 2 cycles per instruction (1-cycle ack + 1 handoff cycle).
- HALT: imem_req=0, inst_valid=0, halted=1. Only reset exits.

Priority when events coincide (highest first): reset > halt > redirect > ack/ready.
- halt in any state: go to HALT next edge; a held inst is discarded; an ack in the same cycle is dropped.
- redirect in FETCH: PC<=target, stay in FETCH. A same-cycle ack is dropped. imem_addr changes only after the edge.
- redirect in VALID: PC<=target, inst_valid<=0, go to FETCH. A same-cycle inst_ready still counts as consumed; PC does not increment.
- redirect in HALT: ignored.

Other rules:
- imem_addr and imem_req never change while waiting for ack, except on redirect, halt or reset.
- pc_plus4 is combinational from pc_out.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- With the macro defined (architectural MIPS branch delay slot):
  - A redirect is latched into a pending register (pend_valid, pend_target).
  - The next sequential instruction (the delay slot) is still fetched and delivered.
  - When that slot is consumed (inst_ready in VALID), PC<=pend_target and pend_valid<=0.
  - A second redirect while pend_valid=1 overwrites pend_target.
  - halt or reset clears pend_valid.
- Without the macro: redirect acts immediately as described in Behaviour; no pending register.

Decomposition:
- mips.h gains the RESET_PC default value, the 2-bit state encodings (FETCH=2'b00, VALID=2'b01, HALT=2'b10), and the word-increment constant 4.
- Natural sub-module: pc_next. It is combinational and selects among PC+4, redirect target, pending target and hold. The FSM and registers stay in inst_fetch.

Test Plan:
- Reset then 3 fetches, imem_ack 1 cycle after req, inst_ready tied high -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; inst_valid high every 2nd cycle; pc_plus4 = pc_out+4.
- inst_ready held low 5 cycles in VALID -> inst, pc_out and inst_valid stable; imem_req=0; PC not incremented.
- redirect with target 0x00400103 in the same cycle as ack -> word dropped; next imem_addr = 0x00400100; no inst_valid for the dropped word.
- halt pulse while in VALID -> next cycle inst_valid=0, halted=1, imem_req=0; a later redirect is ignored; rst_n=0 returns PC to 0x00400000.
- PC=0xFFFFFFFC consumed -> next imem_addr = 0x00000000.
- With FETCH_DELAY_SLOT_EN: redirect to 0x00400200 while delivering 0x00400010 -> the 0x00400014 word is delivered, then imem_addr = 0x00400200. Without the macro -> imem_addr = 0x00400200 immediately.
